// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin stream arbiter.
package arb_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] sel_t;

  function automatic sel_t rr_next(sel_t g);
    return sel_t'(g + 2'd1);
  endfunction

endpackage

// File: rtl/rr_grant_4.sv
// Combinational round-robin grant: one-hot grant plus encoded index, starting the
// search at ptr and wrapping through the remaining channels.
module rr_grant_4
  import arb_pkg::*;
(
  input  logic [3:0] req,
  input  sel_t       ptr,
  output logic [3:0] grant,
  output sel_t       idx
);

  logic [3:0] rot;
  sel_t       off;
  logic       hit;

  always_comb begin
    // Rotating a doubled copy puts the ptr channel at bit 0, so the lowest set
    // bit of rot is the first requester at or after ptr.
    rot = 4'({req, req} >> ptr);
    off = '0;
    hit = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = sel_t'(i);
        hit = 1'b1;
      end
    end
    idx   = sel_t'(ptr + off);
    grant = hit ? (4'b0001 << idx) : 4'b0000;
  end

endmodule

// File: rtl/rr_arb_4_1.sv
// Registered 4:1 round-robin stream merge: grants one pending channel per load,
// captures its payload and reports the source index on out_sel.
module rr_arb_4_1
  import arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   in_valid,
  input  logic [W-1:0] in_data0,
  input  logic [W-1:0] in_data1,
  input  logic [W-1:0] in_data2,
  input  logic [W-1:0] in_data3,
  output logic [3:0]   in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel,
  input  logic         out_ready
);

  sel_t         ptr;
  logic [3:0]   grant;
  sel_t         idx;
  logic         load;
  logic [W-1:0] sel_data;

  rr_grant_4 u_grant (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (idx)
  );

  assign load     = ~out_valid | out_ready;
  // rst_n gate keeps in_ready low during reset, when out_valid=0 would open load.
  assign in_ready = grant & {4{load & rst_n}};

  assign sel_data = ({W{grant[0]}} & in_data0) |
                    ({W{grant[1]}} & in_data1) |
                    ({W{grant[2]}} & in_data2) |
                    ({W{grant[3]}} & in_data3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (|grant) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= idx;
        ptr       <= rr_next(idx);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
